// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: machine word, opcode/funct encodings and the
// fetch queue entry that pairs an instruction with its fetch address.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Primary opcode field, instruction bits [31:26]
  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    REGIMM = 6'b000001,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    ADDIU = 6'b001001,
    SLTI  = 6'b001010,
    SLTIU = 6'b001011,
    ANDI  = 6'b001100,
    ORI   = 6'b001101,
    XORI  = 6'b001110,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    LBU   = 6'b100100,
    LHU   = 6'b100101,
    SB    = 6'b101000,
    SH    = 6'b101001,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000,
    HALT  = 6'b111111
  } opcode_t;

  // Function field for R-type instructions, bits [5:0]
  typedef enum logic [5:0] {
    SLLV  = 6'b000100,
    SRLV  = 6'b000110,
    JR    = 6'b001000,
    ADD   = 6'b100000,
    ADDU  = 6'b100001,
    SUB   = 6'b100010,
    SUBU  = 6'b100011,
    AND   = 6'b100100,
    OR    = 6'b100101,
    XOR   = 6'b100110,
    NOR   = 6'b100111,
    SLT   = 6'b101010,
    SLTU  = 6'b101011
  } funct_t;

  // One buffered fetch: the address it came from and the word returned
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  // Next sequential instruction address, wrapping at the top of memory
  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, inst} pairs between the fetch PC logic
// and decode. Flush empties it in one edge and wins over push and pop.
module fetch_queue #(
  parameter int WORD_W = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] push_pc,
  input  logic [WORD_W-1:0] push_inst,
  output logic [WORD_W-1:0] head_pc,
  output logic [WORD_W-1:0] head_inst,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [WORD_W-1:0] pc_mem [DEPTH];
  logic [WORD_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  // Occupancy flags and the guarded push/pop strobes
  always_comb begin
    empty = (count == '0);
    full = (count == CW'(DEPTH));
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap by simple overflow
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; unoccupied slots are never presented
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      pc_mem[wr_ptr] <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  // Head entry, forced to zero while the queue is empty
  always_comb begin
    head_pc = '0;
    head_inst = '0;
    if (!empty) begin
      head_pc = pc_mem[rd_ptr];
      head_inst = inst_mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues I-cache requests
// and buffers returned words for decode so fetch can run ahead of it.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       inst_valid,
  output logic [WORD_W-1:0]          inst,
  output logic [WORD_W-1:0]          inst_pc,
  output logic [WORD_W-1:0]          inst_npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] fpc;
  logic halted_q;
  logic push;
  logic pop;
  logic q_empty;
  logic q_full;
  logic [WORD_W-1:0] head_pc;
  logic [WORD_W-1:0] head_inst;

  // Request while there is room and nothing has stopped fetch; halt is
  // looked at directly so an outstanding request is dropped immediately
  always_comb begin
    imemREN = !RST && !q_full && !halted_q && !halt && !fault;
    imemaddr = fpc;
    push = imemREN && ihit && !redirect;
    pop = deq && !q_empty && !redirect;
  end

  // Fetch PC: redirect target wins over the sequential advance
  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc <= PC_INIT;
    end else if (redirect) begin
      fpc <= redirect_pc;
    end else if (push) begin
      fpc <= fpc + WORD_W'(4);
    end
  end

  // Sticky halt and misaligned-redirect flags, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted_q <= 1'b0;
      fault <= 1'b0;
    end else begin
      if (halt) begin
        halted_q <= 1'b1;
      end
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        fault <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .WORD_W(WORD_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk(CLK),
    .rst(RST),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .push_pc(fpc),
    .push_inst(imemload),
    .head_pc(head_pc),
    .head_inst(head_inst),
    .count(count),
    .empty(q_empty),
    .full(q_full)
  );

  // Head presentation; the queue already zeroes the head when empty
  always_comb begin
    inst_valid = !q_empty;
    inst = head_inst;
    inst_pc = head_pc;
    inst_npc = q_empty ? '0 : head_pc + WORD_W'(4);
  end

  // Keeps the count port width tied to the internal occupancy width
  if (CW != $bits(count)) begin : g_width_check
    $error("fetch_unit: count width mismatch");
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ihit, redirect, halt, deq;
  logic [31:0] imemload, redirect_pc;
  logic imem_ren, inst_valid, fault;
  logic [31:0] imemaddr, inst, inst_pc, inst_npc;
  logic [2:0] count;

  logic rst2, ihit2;
  logic [31:0] imemload2;
  logic imem_ren2, inst_valid2, fault2;
  logic [31:0] imemaddr2, inst2, inst_pc2, inst_npc2;
  logic [2:0] count2;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.WORD_W(32), .PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst), .imemREN(imem_ren), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .deq(deq),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_npc(inst_npc), .count(count), .fault(fault)
  );

  fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_wrap (
    .CLK(clk), .RST(rst2), .imemREN(imem_ren2), .imemaddr(imemaddr2),
    .ihit(ihit2), .imemload(imemload2), .redirect(1'b0),
    .redirect_pc(32'h0), .halt(1'b0), .deq(1'b0),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_npc(inst_npc2), .count(count2), .fault(fault2)
  );

  // Reference model: architectural view of the fetch front end
  fetch_entry_t model_q[$];
  logic [31:0] model_fpc;
  bit model_halted;
  bit model_fault;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ren(input bit r, input bit h);
    return !r && (model_q.size() != DEPTH) && !model_halted && !h && !model_fault;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_fpc = 32'h0;
    model_halted = 0;
    model_fault = 0;
  endtask

  task automatic compare_all();
    fetch_entry_t head;
    bit v;
    v = (model_q.size() != 0);
    head = v ? model_q[0] : '0;
    checkOutput("imemREN", {31'b0, imem_ren}, {31'b0, model_ren(rst, halt)});
    checkOutput("imemaddr", imemaddr, model_fpc);
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, v});
    checkOutput("inst", inst, head.inst);
    checkOutput("inst_pc", inst_pc, head.pc);
    checkOutput("inst_npc", inst_npc, v ? head.pc + 32'd4 : 32'h0);
    checkOutput("count", {29'b0, count}, model_q.size());
    checkOutput("fault", {31'b0, fault}, {31'b0, model_fault});
  endtask

  // One clock: drive inputs, check mid-cycle, advance the model at the edge
  task automatic applyStimulus(input bit r, input bit hit, input logic [31:0] load,
                               input bit rd, input logic [31:0] rpc,
                               input bit h, input bit d);
    bit ren;
    rst = r; ihit = hit; imemload = load; redirect = rd;
    redirect_pc = rpc; halt = h; deq = d;
    @(negedge clk);
    compare_all();
    ren = model_ren(r, h);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (rd) begin
        model_q.delete();
        model_fpc = rpc;
        if (rpc[1:0] != 2'b00) model_fault = 1;
      end else begin
        if (d && model_q.size() > 0) void'(model_q.pop_front());
        if (ren && hit) begin
          model_q.push_back('{pc: model_fpc, inst: load});
          model_fpc = model_fpc + 32'd4;
        end
      end
      if (h) model_halted = 1;
    end
    #1;
  endtask

  task automatic idle(input bit hit, input bit d);
    applyStimulus(0, hit, $urandom, 0, 32'h0, 0, d);
  endtask

  initial begin
    rst = 1; ihit = 0; imemload = 0; redirect = 0; redirect_pc = 0; halt = 0; deq = 0;
    rst2 = 1; ihit2 = 0; imemload2 = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Wrap-around instance while the main DUT is held in reset
    rst2 = 0;
    @(negedge clk);
    checkOutput("wrap_reset_addr", imemaddr2, 32'hFFFF_FFFC);
    checkOutput("wrap_reset_valid", {31'b0, inst_valid2}, 32'h0);
    ihit2 = 1; imemload2 = 32'h2001_00AA;
    @(negedge clk);
    ihit2 = 0;
    checkOutput("wrap_inst_pc", inst_pc2, 32'hFFFF_FFFC);
    checkOutput("wrap_inst_npc", inst_npc2, 32'h0);
    checkOutput("wrap_addr", imemaddr2, 32'h0);
    checkOutput("wrap_inst", inst2, 32'h2001_00AA);
    @(posedge clk); #1;

    // Reset state
    applyStimulus(1, 1, 32'h0, 0, 32'h0, 0, 0);

    // Fill the queue with no consumer
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 32'h2001_0000 + i, 0, 32'h0, 0, 0);
    idle(1, 0);
    checkOutput("fill_count", {29'b0, count}, 32'd4);
    checkOutput("fill_ren", {31'b0, imem_ren}, 32'h0);
    checkOutput("fill_addr", imemaddr, 32'h10);
    checkOutput("fill_head_pc", inst_pc, 32'h0);

    // Streaming: fetch and consume every cycle
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 1);
    checkOutput("stream_count", {29'b0, count}, 32'd1);

    // Redirect with same-cycle ihit and deq
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 1, 32'h40, 0, 1);
    checkOutput("redir_count", {29'b0, count}, 32'd0);
    checkOutput("redir_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("redir_addr", imemaddr, 32'h40);
    applyStimulus(0, 1, 32'h1234_5678, 0, 32'h0, 0, 0);
    checkOutput("redir_new_pc", inst_pc, 32'h40);

    // Misaligned redirect
    applyStimulus(0, 0, 32'h0, 1, 32'h42, 0, 0);
    for (int i = 0; i < 20; i++) idle(1, 0);
    checkOutput("mis_fault", {31'b0, fault}, 32'h1);
    checkOutput("mis_ren", {31'b0, imem_ren}, 32'h0);
    applyStimulus(1, 1, 32'h0, 0, 32'h0, 0, 0);
    checkOutput("mis_clear", {31'b0, fault}, 32'h0);
    checkOutput("mis_addr", imemaddr, 32'h0);

    // Halt with two entries queued and fpc at 0x10
    applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 1);
    applyStimulus(0, 1, $urandom, 0, 32'h0, 0, 0);
    checkOutput("halt_pre_addr", imemaddr, 32'h10);
    applyStimulus(0, 1, $urandom, 0, 32'h0, 1, 0);
    idle(1, 1);
    idle(1, 1);
    checkOutput("halt_drained", {29'b0, count}, 32'd0);
    for (int i = 0; i < 5; i++) idle(1, 0);
    checkOutput("halt_ren", {31'b0, imem_ren}, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      bit r, rd, h;
      logic [31:0] rpc;
      r = ((model_halted || model_fault) && $urandom_range(0, 4) == 0) || ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 19) == 0);
      rpc = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      h = ($urandom_range(0, 79) == 0);
      applyStimulus(r, $urandom_range(0, 9) < 7, $urandom, rd, rpc, h, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
